// File: rtl/exec_sched.sv
// exec_sched: issue/completion controller in front of the execute stage.
// Routes each accepted op to the ALU result path or to an iterative
// multiply/divide unit, and holds the result in a one-entry output register
// until writeback takes it.
// Build option: define RV32M_EN to enable the multiply/divide path. Without it,
// multiply/divide ops complete at once as illegal ops with a zero result.
module exec_sched #(
    parameter int XLEN       = 32,
    parameter int RD_W       = 5,
    parameter int MD_TIMEOUT = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic            IN_IS_MD,
    input  logic [RD_W-1:0] IN_RD,
    input  logic            IN_FLUSH,
    input  logic [XLEN-1:0] ALU_RESULT,
    output logic            MD_START,
    input  logic            MD_DONE,
    input  logic [XLEN-1:0] MD_RESULT,
    output logic            MD_ABORT,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] OUT_RESULT,
    output logic [RD_W-1:0] OUT_RD,
    output logic            OUT_ILLEGAL,
    output logic            OUT_TIMEOUT,
    output logic            BUSY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
`ifdef RV32M_EN
        MD_WAIT = 2'd1,
`endif
        RESP    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] result_q;
    logic [RD_W-1:0] rd_q;
    logic            illegal_q;
    logic            timeout_q;
    logic            accept;
    logic            load_alu;

`ifdef RV32M_EN
    localparam int              CNT_W    = $clog2(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             start_q;
    logic             abort_q;
    logic             start_next;
    logic             abort_next;
    logic             issue_md;
    logic             load_md;
    logic             load_timeout;
    logic             md_done_seen;

    // MD_DONE only counts once the start pulse has gone low again.
    assign md_done_seen = MD_DONE && !start_q;
    assign MD_START     = start_q;
    assign MD_ABORT     = abort_q;
`else
    logic load_illegal;
    logic unused_md;

    assign unused_md = ^{MD_DONE, MD_RESULT, (MD_TIMEOUT >= 2)};
    assign MD_START  = 1'b0;
    assign MD_ABORT  = 1'b0;
`endif

    // A flush blocks acceptance in the same cycle; a held result can be
    // replaced in the very cycle writeback takes it.
    assign IN_READY = !RST && !IN_FLUSH &&
                      ((state == IDLE) || ((state == RESP) && OUT_READY));
    assign accept   = IN_VALID && IN_READY;

    assign OUT_VALID   = (state == RESP);
    assign OUT_RESULT  = result_q;
    assign OUT_RD      = rd_q;
    assign OUT_ILLEGAL = illegal_q;
    assign OUT_TIMEOUT = timeout_q;
    assign BUSY        = (state != IDLE);

    // Next-state and load decisions; flush outranks every other event.
    always_comb begin
        state_next   = state;
        load_alu     = 1'b0;
`ifdef RV32M_EN
        start_next   = 1'b0;
        abort_next   = 1'b0;
        issue_md     = 1'b0;
        load_md      = 1'b0;
        load_timeout = 1'b0;
`else
        load_illegal = 1'b0;
`endif
        case (state)
            IDLE, RESP: begin
                if ((state == RESP) && (IN_FLUSH || OUT_READY)) begin
                    state_next = IDLE;
                end
                if (accept) begin
                    if (IN_IS_MD) begin
`ifdef RV32M_EN
                        issue_md   = 1'b1;
                        start_next = 1'b1;
                        state_next = MD_WAIT;
`else
                        load_illegal = 1'b1;
                        state_next   = RESP;
`endif
                    end else begin
                        load_alu   = 1'b1;
                        state_next = RESP;
                    end
                end
            end
`ifdef RV32M_EN
            MD_WAIT: begin
                if (IN_FLUSH) begin
                    abort_next = 1'b1;
                    state_next = IDLE;
                end else if (md_done_seen) begin
                    load_md    = 1'b1;
                    state_next = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    abort_next   = 1'b1;
                    load_timeout = 1'b1;
                    state_next   = RESP;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result register, handshake pulses and the multiply/divide wait counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            result_q  <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef RV32M_EN
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            if (load_alu) begin
                result_q  <= ALU_RESULT;
                rd_q      <= IN_RD;
                illegal_q <= 1'b0;
                timeout_q <= 1'b0;
            end
`ifdef RV32M_EN
            start_q <= start_next;
            abort_q <= abort_next;
            if (issue_md) begin
                rd_q      <= IN_RD;
                illegal_q <= 1'b0;
                timeout_q <= 1'b0;
                cnt_q     <= '0;
            end else if (state == MD_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (load_md) begin
                result_q <= MD_RESULT;
            end
            if (load_timeout) begin
                result_q  <= '0;
                timeout_q <= 1'b1;
            end
`else
            if (load_illegal) begin
                result_q  <= '0;
                rd_q      <= IN_RD;
                illegal_q <= 1'b1;
                timeout_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_exec_sched.sv
// tb_exec_sched: self-checking bench for exec_sched (directed scenarios plus a
// randomized run against a transaction-level model). Handles both builds,
// with and without RV32M_EN.
module tb_exec_sched;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic        IN_IS_MD;
    logic [4:0]  IN_RD;
    logic        IN_FLUSH;
    logic [31:0] ALU_RESULT;
    logic        MD_START;
    logic        MD_DONE;
    logic [31:0] MD_RESULT;
    logic        MD_ABORT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_RESULT;
    logic [4:0]  OUT_RD;
    logic        OUT_ILLEGAL;
    logic        OUT_TIMEOUT;
    logic        BUSY;

    int checks;
    int errors;

    exec_sched #(.XLEN(32), .RD_W(5), .MD_TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_IS_MD(IN_IS_MD),
        .IN_RD(IN_RD), .IN_FLUSH(IN_FLUSH), .ALU_RESULT(ALU_RESULT),
        .MD_START(MD_START), .MD_DONE(MD_DONE), .MD_RESULT(MD_RESULT),
        .MD_ABORT(MD_ABORT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_RESULT(OUT_RESULT), .OUT_RD(OUT_RD), .OUT_ILLEGAL(OUT_ILLEGAL),
        .OUT_TIMEOUT(OUT_TIMEOUT), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Moves to just after the next rising edge; inputs are driven from here.
    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; IN_VALID = 1'b0; IN_IS_MD = 1'b0; IN_RD = '0; IN_FLUSH = 1'b0;
        ALU_RESULT = '0; MD_DONE = 1'b0; MD_RESULT = '0; OUT_READY = 1'b0;
        next_cycle;
        next_cycle;
        #1;
        checks++; if (IN_READY !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready got %b exp 0", IN_READY); end
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %b exp 0", OUT_VALID); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", BUSY); end
        checks++; if (MD_START !== 1'b0 || MD_ABORT !== 1'b0) begin errors++; $display("[TB] FAIL rst_md got start %b abort %b exp 0 0", MD_START, MD_ABORT); end
        RST = 1'b0;
        #1;
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready got %b exp 1", IN_READY); end
        // Load a result, then reset in the middle of holding it.
        next_cycle;
        IN_VALID = 1'b1; IN_IS_MD = 1'b0; ALU_RESULT = 32'h0000_1234; IN_RD = 5'd9;
        next_cycle;
        IN_VALID = 1'b0;
        #1;
        checks++; if (OUT_VALID !== 1'b1 || OUT_RESULT !== 32'h0000_1234) begin errors++; $display("[TB] FAIL pre_rst_load got valid %b result %h exp 1 00001234", OUT_VALID, OUT_RESULT); end
        RST = 1'b1; IN_VALID = 1'b1;
        #1;
        checks++; if (IN_READY !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ready got %b exp 0", IN_READY); end
        next_cycle;
        #1;
        checks++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got valid %b busy %b exp 0 0", OUT_VALID, BUSY); end
        checks++; if (OUT_RESULT !== 32'h0 || OUT_RD !== 5'd0 || OUT_ILLEGAL !== 1'b0 || OUT_TIMEOUT !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_regs got result %h rd %0d ill %b to %b exp all 0", OUT_RESULT, OUT_RD, OUT_ILLEGAL, OUT_TIMEOUT); end
        RST = 1'b0; IN_VALID = 1'b0;
    endtask

    task automatic test_alu;
        logic [31:0] vals [3];
        logic [4:0]  rds [3];
        next_cycle;
        IN_VALID = 1'b1; IN_IS_MD = 1'b0; ALU_RESULT = 32'h0000_0005; IN_RD = 5'd3; OUT_READY = 1'b1;
        #1;
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL alu_ready got %b exp 1", IN_READY); end
        next_cycle;
        IN_VALID = 1'b0;
        #1;
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("[TB] FAIL alu_valid got %b exp 1", OUT_VALID); end
        checks++; if (OUT_RESULT !== 32'h5 || OUT_RD !== 5'd3) begin errors++; $display("[TB] FAIL alu_data got %h rd %0d exp 00000005 rd 3", OUT_RESULT, OUT_RD); end
        next_cycle;
        #1;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL alu_drain got %b exp 0", OUT_VALID); end
        // Three ops back to back with writeback always ready.
        for (int i = 0; i < 3; i++) begin
            vals[i] = $urandom;
            rds[i]  = 5'($urandom);
        end
        for (int i = 0; i < 5; i++) begin
            next_cycle;
            IN_VALID = (i < 3);
            if (i < 3) begin
                ALU_RESULT = vals[i];
                IN_RD      = rds[i];
            end
            #1;
            if (i < 3) begin
                checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready[%0d] got %b exp 1", i, IN_READY); end
            end
            if (i >= 1 && i <= 3) begin
                checks++; if (OUT_VALID !== 1'b1 || OUT_RESULT !== vals[i-1] || OUT_RD !== rds[i-1]) begin
                    errors++; $display("[TB] FAIL b2b_out[%0d] got valid %b %h rd %0d exp 1 %h rd %0d", i, OUT_VALID, OUT_RESULT, OUT_RD, vals[i-1], rds[i-1]); end
            end else if (i == 4) begin
                checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end got %b exp 0", OUT_VALID); end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [4:0] rd;
        rd = 5'($urandom);
        next_cycle;
        IN_VALID = 1'b1; IN_IS_MD = 1'b0; ALU_RESULT = 32'h0000_00AA; IN_RD = rd; OUT_READY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next_cycle;
            ALU_RESULT = 32'h0000_0055; IN_RD = rd + 5'd1;
            #1;
            checks++; if (OUT_VALID !== 1'b1 || OUT_RESULT !== 32'hAA || OUT_RD !== rd) begin
                errors++; $display("[TB] FAIL hold[%0d] got valid %b %h rd %0d exp 1 000000aa rd %0d", k, OUT_VALID, OUT_RESULT, OUT_RD, rd); end
            checks++; if (IN_READY !== 1'b0) begin errors++; $display("[TB] FAIL hold_ready[%0d] got %b exp 0", k, IN_READY); end
        end
        next_cycle;
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        #1;
        checks++; if (OUT_VALID !== 1'b1 || IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL release got valid %b ready %b exp 1 1", OUT_VALID, IN_READY); end
        next_cycle;
        #1;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL consumed got %b exp 0", OUT_VALID); end
    endtask

    task automatic test_flush_resp;
        next_cycle;
        IN_VALID = 1'b1; IN_IS_MD = 1'b0; ALU_RESULT = 32'hDEAD_0001; IN_RD = 5'd4; OUT_READY = 1'b1;
        next_cycle;
        IN_FLUSH = 1'b1; ALU_RESULT = 32'hDEAD_0002;
        #1;
        checks++; if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin errors++; $display("[TB] FAIL flush_resp_cycle got valid %b ready %b exp 1 0", OUT_VALID, IN_READY); end
        next_cycle;
        IN_FLUSH = 1'b0; IN_VALID = 1'b0;
        #1;
        checks++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || MD_ABORT !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_resp_after got valid %b busy %b abort %b exp 0 0 0", OUT_VALID, BUSY, MD_ABORT); end
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL flush_resp_ready got %b exp 1", IN_READY); end
    endtask

`ifdef RV32M_EN
    task automatic test_md;
        int starts;
        starts = 0;
        next_cycle;
        IN_VALID = 1'b1; IN_IS_MD = 1'b1; IN_RD = 5'd7; ALU_RESULT = $urandom; OUT_READY = 1'b1;
        #1;
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL md_accept got %b exp 1", IN_READY); end
        for (int c = 1; c <= 7; c++) begin
            next_cycle;
            IN_VALID = (c <= 5); IN_IS_MD = 1'b0; ALU_RESULT = $urandom; IN_RD = 5'd1;
            MD_DONE = (c == 1 || c == 5);
            MD_RESULT = (c == 5) ? 32'h0000_0C00 : $urandom;
            #1;
            if (MD_START === 1'b1) starts++;
            checks++; if (MD_START !== (c == 1)) begin errors++; $display("[TB] FAIL md_start[%0d] got %b exp %b", c, MD_START, (c == 1)); end
            checks++; if (OUT_VALID !== (c == 6)) begin errors++; $display("[TB] FAIL md_valid[%0d] got %b exp %b", c, OUT_VALID, (c == 6)); end
            if (c <= 5) begin
                checks++; if (IN_READY !== 1'b0) begin errors++; $display("[TB] FAIL md_stall[%0d] got %b exp 0", c, IN_READY); end
            end
            if (c == 6) begin
                checks++; if (OUT_RESULT !== 32'hC00 || OUT_RD !== 5'd7 || OUT_TIMEOUT !== 1'b0) begin
                    errors++; $display("[TB] FAIL md_data got %h rd %0d to %b exp 00000c00 rd 7 to 0", OUT_RESULT, OUT_RD, OUT_TIMEOUT); end
            end
        end
        MD_DONE = 1'b0;
        checks++; if (starts != 1) begin errors++; $display("[TB] FAIL md_start_count got %0d exp 1", starts); end
    endtask

    task automatic test_flush_md;
        int aborts;
        aborts = 0;
        next_cycle;
        IN_VALID = 1'b1; IN_IS_MD = 1'b1; IN_RD = 5'd12; OUT_READY = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle;
            IN_IS_MD = 1'b0;
            IN_VALID = (c == 2 || c == 3);
            IN_FLUSH = (c == 2);
            MD_DONE = (c == 2);
            MD_RESULT = 32'hBAD0_BAD0;
            ALU_RESULT = 32'h0000_0777; IN_RD = 5'd13;
            #1;
            if (MD_ABORT === 1'b1) aborts++;
            checks++; if (MD_ABORT !== (c == 3)) begin errors++; $display("[TB] FAIL flush_abort[%0d] got %b exp %b", c, MD_ABORT, (c == 3)); end
            checks++; if (OUT_VALID !== (c == 4)) begin errors++; $display("[TB] FAIL flush_valid[%0d] got %b exp %b", c, OUT_VALID, (c == 4)); end
            if (c == 2) begin
                checks++; if (IN_READY !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready got %b exp 0", IN_READY); end
            end
            if (c == 3) begin
                checks++; if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("[TB] FAIL flush_next got ready %b busy %b exp 1 0", IN_READY, BUSY); end
            end
            if (c == 4) begin
                checks++; if (OUT_RESULT !== 32'h777 || OUT_RD !== 5'd13) begin errors++; $display("[TB] FAIL flush_next_data got %h rd %0d exp 00000777 rd 13", OUT_RESULT, OUT_RD); end
            end
        end
        MD_DONE = 1'b0;
        checks++; if (aborts != 1) begin errors++; $display("[TB] FAIL flush_abort_count got %0d exp 1", aborts); end
    endtask

    task automatic test_timeout;
        next_cycle;
        IN_VALID = 1'b1; IN_IS_MD = 1'b1; IN_RD = 5'd21; OUT_READY = 1'b0; MD_DONE = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            next_cycle;
            IN_IS_MD = 1'b0;
            IN_VALID = (c == 11);
            OUT_READY = (c >= 11);
            ALU_RESULT = 32'h0000_3141; IN_RD = 5'd22;
            #1;
            if (c <= 10) begin
                checks++; if (MD_START !== (c == 1)) begin errors++; $display("[TB] FAIL to_start[%0d] got %b exp %b", c, MD_START, (c == 1)); end
                checks++; if (MD_ABORT !== (c == 9)) begin errors++; $display("[TB] FAIL to_abort[%0d] got %b exp %b", c, MD_ABORT, (c == 9)); end
                checks++; if (OUT_VALID !== (c >= 9)) begin errors++; $display("[TB] FAIL to_valid[%0d] got %b exp %b", c, OUT_VALID, (c >= 9)); end
            end
            if (c == 9 || c == 10) begin
                checks++; if (OUT_TIMEOUT !== 1'b1 || OUT_RESULT !== 32'h0 || OUT_RD !== 5'd21) begin
                    errors++; $display("[TB] FAIL to_data[%0d] got to %b %h rd %0d exp 1 00000000 rd 21", c, OUT_TIMEOUT, OUT_RESULT, OUT_RD); end
            end
            if (c == 11) begin
                checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL to_reload_ready got %b exp 1", IN_READY); end
            end
            if (c == 12) begin
                checks++; if (OUT_VALID !== 1'b1 || OUT_RESULT !== 32'h3141 || OUT_TIMEOUT !== 1'b0) begin
                    errors++; $display("[TB] FAIL to_reload got valid %b %h to %b exp 1 00003141 0", OUT_VALID, OUT_RESULT, OUT_TIMEOUT); end
            end
            if (c == 13) begin
                checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL to_drain got %b exp 0", OUT_VALID); end
            end
        end
    endtask
`else
    task automatic test_illegal;
        next_cycle;
        IN_VALID = 1'b1; IN_IS_MD = 1'b1; IN_RD = 5'd2; ALU_RESULT = 32'h1357_9BDF; OUT_READY = 1'b1;
        MD_DONE = 1'b1; MD_RESULT = 32'hFFFF_0000;
        #1;
        checks++; if (IN_READY !== 1'b1 || MD_START !== 1'b0) begin errors++; $display("[TB] FAIL ill_accept got ready %b start %b exp 1 0", IN_READY, MD_START); end
        next_cycle;
        IN_VALID = 1'b0; MD_DONE = 1'b0;
        #1;
        checks++; if (OUT_VALID !== 1'b1 || OUT_ILLEGAL !== 1'b1) begin errors++; $display("[TB] FAIL ill_valid got valid %b ill %b exp 1 1", OUT_VALID, OUT_ILLEGAL); end
        checks++; if (OUT_RESULT !== 32'h0 || OUT_RD !== 5'd2 || MD_START !== 1'b0) begin
            errors++; $display("[TB] FAIL ill_data got %h rd %0d start %b exp 00000000 rd 2 start 0", OUT_RESULT, OUT_RD, MD_START); end
        next_cycle;
        #1;
        checks++; if (OUT_VALID !== 1'b0 || MD_START !== 1'b0) begin errors++; $display("[TB] FAIL ill_drain got valid %b start %b exp 0 0", OUT_VALID, MD_START); end
    endtask
`endif

    // Random traffic checked against a transaction model: at most one result
    // waiting for writeback, at most one multiply/divide op outstanding.
    task automatic test_random;
        bit          have_res;
        bit          md_pend;
        bit          exp_ready;
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        logic [4:0]  md_rd;
        bit          exp_ill;
        bit          exp_to;
        int          start_at;
        int          done_at;
        have_res = 0; md_pend = 0; start_at = -10; done_at = -10;
        exp_res = '0; exp_rd = '0; md_rd = '0; exp_ill = 0; exp_to = 0;
        next_cycle;
        RST = 1'b1; IN_VALID = 1'b0; IN_FLUSH = 1'b0; MD_DONE = 1'b0;
        next_cycle;
        RST = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) next_cycle;
            IN_VALID   = ($urandom_range(0, 3) != 0);
            IN_IS_MD   = ($urandom_range(0, 2) == 0);
            IN_RD      = 5'($urandom);
            ALU_RESULT = $urandom;
            OUT_READY  = ($urandom_range(0, 3) != 0);
            MD_RESULT  = $urandom;
            if (md_pend && cyc == done_at) MD_DONE = 1'b1;
            else MD_DONE = (!md_pend || cyc == start_at) && ($urandom_range(0, 7) == 0);
            exp_ready = !md_pend && (!have_res || OUT_READY);
            #1;
            checks++; if (IN_READY !== exp_ready) begin errors++; $display("[TB] FAIL rnd_ready@%0d got %b exp %b", cyc, IN_READY, exp_ready); end
            checks++; if (OUT_VALID !== have_res) begin errors++; $display("[TB] FAIL rnd_valid@%0d got %b exp %b", cyc, OUT_VALID, have_res); end
            checks++; if (BUSY !== (have_res || md_pend)) begin errors++; $display("[TB] FAIL rnd_busy@%0d got %b exp %b", cyc, BUSY, (have_res || md_pend)); end
            checks++; if (MD_START !== (cyc == start_at) || MD_ABORT !== 1'b0) begin
                errors++; $display("[TB] FAIL rnd_md@%0d got start %b abort %b exp %b 0", cyc, MD_START, MD_ABORT, (cyc == start_at)); end
            if (have_res) begin
                checks++; if (OUT_RESULT !== exp_res || OUT_RD !== exp_rd || OUT_ILLEGAL !== exp_ill || OUT_TIMEOUT !== exp_to) begin
                    errors++; $display("[TB] FAIL rnd_data@%0d got %h rd %0d ill %b to %b exp %h rd %0d ill %b to %b",
                                       cyc, OUT_RESULT, OUT_RD, OUT_ILLEGAL, OUT_TIMEOUT, exp_res, exp_rd, exp_ill, exp_to); end
            end
            if (have_res && OUT_READY) have_res = 0;
            if (md_pend && cyc == done_at) begin
                md_pend = 0; have_res = 1; exp_res = MD_RESULT; exp_rd = md_rd; exp_ill = 0; exp_to = 0;
            end
            if (IN_VALID && exp_ready) begin
                if (!IN_IS_MD) begin
                    have_res = 1; exp_res = ALU_RESULT; exp_rd = IN_RD; exp_ill = 0; exp_to = 0;
                end else begin
`ifdef RV32M_EN
                    md_pend = 1; md_rd = IN_RD; start_at = cyc + 1;
                    done_at = cyc + 1 + $urandom_range(1, 4);
`else
                    have_res = 1; exp_res = '0; exp_rd = IN_RD; exp_ill = 1; exp_to = 0;
`endif
                end
            end
        end
        next_cycle;
        IN_VALID = 1'b0; MD_DONE = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_alu;
        test_backpressure;
        test_flush_resp;
`ifdef RV32M_EN
        test_md;
        test_flush_md;
        test_timeout;
`else
        test_illegal;
`endif
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_sched.md
# exec_sched

Issue/completion controller in front of the execute stage. It accepts one decoded op per handshake and routes it to one of two resources:
- the single-cycle ALU result path;
- an iterative multiply/divide unit with a start/done handshake.

It holds the finished result in a one-entry output register until writeback takes it, stalls decode while an op is in flight, and handles pipeline flushes and a stuck multiply/divide unit.

## Interface
Parameters:
- XLEN, 32, datapath width.
- RD_W, 5, destination-register tag width.
- MD_TIMEOUT, 64, maximum cycles to wait for MD_DONE; minimum 2.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN_VALID  in  1  decode presents an op.
- IN_READY  out  1  op is accepted in this cycle when IN_VALID && IN_READY.
- IN_IS_MD  in  1  op targets the multiply/divide unit (otherwise the ALU).
- IN_RD  in  RD_W  destination tag.
- IN_FLUSH  in  1  kill any in-flight or held op.
- ALU_RESULT  in  XLEN  ALU output for the op currently presented.
- MD_START  out  1  one-cycle start pulse to the multiply/divide unit.
- MD_DONE  in  1  multiply/divide result is valid.
- MD_RESULT  in  XLEN  multiply/divide result.
- MD_ABORT  out  1  one-cycle pulse that cancels the multiply/divide unit.
- OUT_VALID  out  1  result register is valid.
- OUT_READY  in  1  writeback takes the result.
- OUT_RESULT  out  XLEN  result.
- OUT_RD  out  RD_W  tag of the result.
- OUT_ILLEGAL  out  1  op is unsupported; OUT_RESULT is 0.
- OUT_TIMEOUT  out  1  multiply/divide unit timed out; OUT_RESULT is 0.
- BUSY  out  1  state is not IDLE.

## Operation
States: IDLE, MD_WAIT, RESP.

- IN_READY = !RST && !IN_FLUSH && (IDLE || (RESP && OUT_READY)).
- Accepted ALU op: capture ALU_RESULT and IN_RD into the result register; go to RESP.
- Accepted MD op:
  - capture IN_RD;
  - set MD_START for the next cycle only;
  - clear the timeout counter;
  - go to MD_WAIT.
- MD_WAIT:
  - MD_DONE is sampled only when MD_START is low.
  - On MD_DONE: capture MD_RESULT and go to RESP.
  - The counter increments every MD_WAIT cycle.
  - When the counter reaches MD_TIMEOUT-1 with no MD_DONE: pulse MD_ABORT, load result 0 with OUT_TIMEOUT=1, go to RESP.
- RESP:
  - OUT_VALID=1.
  - On OUT_READY with a new accept in the same cycle: reload the register and stay in RESP.
  - On OUT_READY with no accept: go to IDLE.
  - Without OUT_READY: hold all OUT_* stable.
- MD_DONE outside MD_WAIT is ignored.
- IN_FLUSH has priority over every other event:
  - in MD_WAIT: pulse MD_ABORT next cycle; go to IDLE; no output is produced;
  - in RESP: drop the result (OUT_VALID=0 next cycle) even if OUT_READY is high; go to IDLE;
  - MD_DONE in the same cycle as the flush is discarded;
  - no accept occurs in a flush cycle.

## Timing
- Reset values: state IDLE, OUT_VALID=0, OUT_RESULT=0, OUT_RD=0, OUT_ILLEGAL=0, OUT_TIMEOUT=0, MD_START=0, MD_ABORT=0, BUSY=0, counter=0.
- IN_READY is 0 while RST=1. With IN_FLUSH low it is 1 in the first cycle after reset.
- ALU latency: accept in cycle N gives OUT_VALID in cycle N+1. With OUT_READY held high, throughput is one op per cycle.
- MD: accept in cycle N gives MD_START in N+1; MD_DONE is first sampled in N+2.
- MD_DONE sampled in cycle D gives OUT_VALID in D+1. MD_DONE in N+2 gives a total of 3 cycles.
- Timeout: MD_ABORT and OUT_VALID with OUT_TIMEOUT are both asserted in cycle N+1+MD_TIMEOUT.
- Flush in cycle F: MD_ABORT (when applicable) and OUT_VALID=0 in F+1; IN_READY may be 1 in F+1.
- Reset asserted mid-operation: all state returns to reset values on the next edge. MD_ABORT is not pulsed; the multiply/divide unit receives the same reset.

## Configuration
- RV32M_EN defined: behaviour exactly as described above.
- RV32M_EN undefined:
  - IN_IS_MD ops complete like ALU ops: OUT_VALID in N+1, OUT_RESULT=0, OUT_ILLEGAL=1.
  - MD_START and MD_ABORT are tied to 0.
  - MD_DONE and MD_RESULT are unused.
  - MD_WAIT and the timeout counter are not built.

## Test plan
- ALU op with ALU_RESULT=0x0000_0005, IN_RD=3, OUT_READY=1 -> OUT_VALID in the next cycle with OUT_RESULT=5, OUT_RD=3; three back-to-back ops give 3 consecutive OUT_VALID cycles.
- MD op with IN_RD=7 and MD_DONE returned 4 cycles after MD_START with MD_RESULT=0x0000_0C00 -> exactly one MD_START pulse; IN_READY=0 throughout; OUT_RESULT=0xC00, OUT_RD=7 one cycle after MD_DONE.
- ALU result 0xAA with OUT_READY=0 for 5 cycles -> OUT_VALID, OUT_RESULT and OUT_RD stable for all 5 cycles; IN_READY=0; the result is consumed when OUT_READY rises.
- IN_FLUSH during MD_WAIT, including a cycle where MD_DONE coincides with IN_FLUSH -> one MD_ABORT pulse; no OUT_VALID; next op accepted in the following cycle.
- MD_TIMEOUT=8 and MD_DONE never asserted -> MD_ABORT and OUT_VALID with OUT_TIMEOUT=1, OUT_RESULT=0 in cycle N+9.
- RV32M_EN undefined, MD op with IN_RD=2 -> OUT_VALID in N+1 with OUT_ILLEGAL=1, OUT_RESULT=0, OUT_RD=2; MD_START never asserts.
